// File: rtl/arbiter_wb.sv
// Two-master round-robin Wishbone arbiter with a stall watchdog.
// A granted master owns the bus until it drops cyc or its transfer times out.
module arbiter_wb #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [2*WB_DATA_WIDTH-1:0] m_dat_i,
    input  logic [1:0]                 m_we_i,
    input  logic [7:0]                 m_sel_i,
    input  logic [2*WB_ADDR_WIDTH-1:0] m_adr_i,
    input  logic [1:0]                 m_cyc_i,
    input  logic [1:0]                 m_stb_i,
    output logic [WB_DATA_WIDTH-1:0]   m_dat_o,
    output logic [1:0]                 m_ack_o,
    output logic [1:0]                 m_err_o,
    output logic [WB_DATA_WIDTH-1:0]   s_dat_o,
    output logic                       s_we_o,
    output logic [3:0]                 s_sel_o,
    output logic [WB_ADDR_WIDTH-1:0]   s_adr_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]   s_dat_i,
    input  logic                       s_ack_i,
    output logic [1:0]                 grant_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant;
    logic [1:0]  grant_next;
    logic        last_grant;
    logic        last_grant_next;
    logic [15:0] stall_cnt;
    logic [15:0] stall_cnt_next;

    logic                     busy;
    logic                     owner;
    logic                     timeout;
    logic                     own_cyc;
    logic                     own_stb;
    logic                     own_we;
    logic [3:0]               own_sel;
    logic [WB_DATA_WIDTH-1:0] own_dat;
    logic [WB_ADDR_WIDTH-1:0] own_adr;

    assign busy  = (state == BUSY);
    assign owner = grant[1];

    always_comb begin
        own_cyc = owner ? m_cyc_i[1] : m_cyc_i[0];
        own_stb = owner ? m_stb_i[1] : m_stb_i[0];
        own_we  = owner ? m_we_i[1]  : m_we_i[0];
        own_sel = owner ? m_sel_i[7:4] : m_sel_i[3:0];
        own_dat = owner ? m_dat_i[2*WB_DATA_WIDTH-1:WB_DATA_WIDTH] : m_dat_i[WB_DATA_WIDTH-1:0];
        own_adr = owner ? m_adr_i[2*WB_ADDR_WIDTH-1:WB_ADDR_WIDTH] : m_adr_i[WB_ADDR_WIDTH-1:0];
    end

    // An ack arriving on the last allowed stall cycle beats the timeout.
    assign timeout = busy && (stall_cnt == STALL_LIMIT) && !s_ack_i;

    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_adr_o = own_adr;
    assign s_we_o  = busy & own_we;
    assign s_cyc_o = busy & own_cyc & ~timeout;
    assign s_stb_o = busy & own_stb & ~timeout;
    assign m_ack_o = busy ? (grant & {2{s_ack_i}}) : 2'b00;
    assign m_err_o = timeout ? grant : 2'b00;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            stall_cnt  <= 16'd0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            stall_cnt  <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        stall_cnt_next  = 16'd0;
        case (state)
            IDLE: begin
                grant_next = 2'b00;
                if (m_cyc_i != 2'b00) begin
                    state_next = BUSY;
                    if (m_cyc_i == 2'b11) begin
                        grant_next = last_grant ? 2'b01 : 2'b10;
                    end else begin
                        grant_next = m_cyc_i;
                    end
                end
            end
            BUSY: begin
                if (!own_cyc || timeout) begin
                    state_next      = IDLE;
                    grant_next      = 2'b00;
                    last_grant_next = owner;
                end else if (s_ack_i) begin
                    stall_cnt_next = 16'd0;
                end else if (s_stb_o && (stall_cnt != 16'hFFFF)) begin
                    stall_cnt_next = stall_cnt + 16'd1;
                end else begin
                    stall_cnt_next = stall_cnt;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

endmodule
